data_memory: RTL and testbench

Byte-addressable RV32I data memory with a valid/ready request port, a fixed and parametrised response latency, and sub-word load/store support: byte, halfword and word accesses, with sign or zero extension on loads. It sits between the core's memory stage and a word-organised storage array. It replaces the word-only, combinational-read memory in the core's load/store path. Illegal accesses are reported as faults; the array is never corrupted by them.

---
 rtl/data_memory.sv | 162 ++++++++++++++++
 tb/tb_data_memory.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Byte-addressable RV32I data memory: valid/ready request port, fixed LATENCY
// response pulse, B/H/W loads and stores with sign/zero extension and fault reporting.
module data_memory #(
   parameter int WORDS     = 1024,
   parameter int LATENCY   = 1,
   parameter     INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault
);

   localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_mem [WORDS];
   logic [31:0] r_pend_rdata;
   logic        r_pend_fault;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_fault;

   logic          w_accept;
   logic          w_in_range;
   logic [AW-1:0] w_idx;
   logic          w_fault;
   logic [31:0]   w_word;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_fmt;
   logic [31:0]   w_load_data;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata_rep;

   assign req_ready  = ~rst & (r_state != S_WAIT);
   assign w_accept   = req_valid & req_ready;
   assign w_in_range = ({2'b00, req_addr[31:2]} < 32'(WORDS));
   assign w_idx      = req_addr[AW+1:2];

   assign w_fault = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11)
                  | (req_write & req_funct3[2])
                  | ((req_funct3[1:0] == 2'b01) & req_addr[0])
                  | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]))
                  | ~w_in_range;

   // Out-of-range addresses fault anyway; the guard keeps the read index legal.
   assign w_word = w_in_range ? r_mem[w_idx] : '0;

   always_comb begin
      w_byte = w_word[7:0];
      case (req_addr[1:0])
         2'd0:    w_byte = w_word[7:0];
         2'd1:    w_byte = w_word[15:8];
         2'd2:    w_byte = w_word[23:16];
         default: w_byte = w_word[31:24];
      endcase
      w_half = req_addr[1] ? w_word[31:16] : w_word[15:0];
      case (req_funct3)
         3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_fmt = {24'd0, w_byte};
         3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
         3'b101:  w_fmt = {16'd0, w_half};
         3'b010:  w_fmt = w_word;
         default: w_fmt = '0;
      endcase
      w_load_data = (req_write | w_fault) ? 32'd0 : w_fmt;
   end

   always_comb begin
      w_be        = 4'b1111;
      w_wdata_rep = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            w_be        = 4'b0001 << req_addr[1:0];
            w_wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_rep = {2{req_wdata[15:0]}};
         end
         default: begin
            w_be        = 4'b1111;
            w_wdata_rep = req_wdata;
         end
      endcase
   end

   // Stores commit at the acceptance edge; the array is never reset.
   always_ff @(posedge clk) begin
      if (w_accept && req_write && !w_fault) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_pend_rdata <= '0;
         r_pend_fault <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_fault <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_fault <= 1'b0;
         case (r_state)
            S_IDLE, S_RESP: begin
               if (w_accept) begin
                  if (LATENCY == 1) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= w_load_data;
                     r_resp_fault <= w_fault;
                  end else begin
                     r_state      <= S_WAIT;
                     r_cnt        <= 4'(LATENCY - 2);
                     r_pend_rdata <= w_load_data;
                     r_pend_fault <= w_fault;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= r_pend_rdata;
                  r_resp_fault <= r_pend_fault;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_fault = r_resp_fault;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: a LATENCY=1 instance driven from a vector table and a
// LATENCY=4 instance for handshake spacing and mid-operation reset.
module tb_data_memory;

   localparam int WORDS = 64;

   logic        clk = 1'b0;
   logic [31:0] cyc = '0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        mon_en = 1'b0;

   // queue entry: [48:33] due cycle, [32] fault, [31:0] rdata
   logic [48:0] exp_q1[$];
   logic [48:0] exp_q4[$];

   logic        rst1 = 1'b1, v1 = 1'b0, wr1 = 1'b0;
   logic [31:0] a1 = '0, wd1 = '0;
   logic [2:0]  f31 = '0;
   logic        rdy1, rv1, rf1;
   logic [31:0] rd1;

   logic        rst4 = 1'b1, v4 = 1'b0, wr4 = 1'b0;
   logic [31:0] a4 = '0, wd4 = '0;
   logic [2:0]  f34 = '0;
   logic        rdy4, rv4, rf4;
   logic [31:0] rd4;

   data_memory #(.WORDS(WORDS), .LATENCY(1), .INIT_FILE("")) dut1 (
      .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(rdy1), .req_write(wr1),
      .req_addr(a1), .req_wdata(wd1), .req_funct3(f31),
      .resp_valid(rv1), .resp_rdata(rd1), .resp_fault(rf1));

   data_memory #(.WORDS(WORDS), .LATENCY(4), .INIT_FILE("")) dut4 (
      .clk(clk), .rst(rst4), .req_valid(v4), .req_ready(rdy4), .req_write(wr4),
      .req_addr(a4), .req_wdata(wd4), .req_funct3(f34),
      .resp_valid(rv4), .resp_rdata(rd4), .resp_fault(rf4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitors: every pulse must match the head of its queue at its due cycle.
   always @(negedge clk) begin
      logic [48:0] e;
      if (mon_en) begin
         if (rv1) begin
            if (exp_q1.size() == 0) chk("l1_unexpected_resp", {31'd0, rv1}, 32'd0);
            else begin
               e = exp_q1.pop_front();
               chk("l1_rdata", rd1, e[31:0]);
               chk("l1_fault", {31'd0, rf1}, {31'd0, e[32]});
               chk("l1_resp_cycle", {16'd0, cyc[15:0]}, {16'd0, e[48:33]});
            end
         end else begin
            chk("l1_idle_rdata", rd1 | {31'd0, rf1}, 32'd0);
            if (exp_q1.size() != 0 && exp_q1[0][48:33] <= cyc[15:0]) begin
               e = exp_q1.pop_front();
               chk("l1_resp_missing", {31'd0, rv1}, 32'd1);
            end
         end
         if (rv4) begin
            if (exp_q4.size() == 0) chk("l4_unexpected_resp", {31'd0, rv4}, 32'd0);
            else begin
               e = exp_q4.pop_front();
               chk("l4_rdata", rd4, e[31:0]);
               chk("l4_fault", {31'd0, rf4}, {31'd0, e[32]});
               chk("l4_resp_cycle", {16'd0, cyc[15:0]}, {16'd0, e[48:33]});
            end
         end else begin
            chk("l4_idle_rdata", rd4 | {31'd0, rf4}, 32'd0);
            if (exp_q4.size() != 0 && exp_q4[0][48:33] <= cyc[15:0]) begin
               e = exp_q4.pop_front();
               chk("l4_resp_missing", {31'd0, rv4}, 32'd1);
            end
         end
      end
   end

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rd;
      logic        exp_f;
   } vec_t;

   vec_t tbl[$];

   // Called at a negedge; drives one LATENCY=1 request and returns at the next negedge.
   task automatic drv1(input vec_t t);
      logic [31:0] acc;
      v1 = 1'b1; wr1 = t.wr; a1 = t.addr; wd1 = t.wdata; f31 = t.f3;
      #1;
      chk("l1_ready", {31'd0, rdy1}, 32'd1);
      acc = cyc + 32'd1;
      exp_q1.push_back({acc[15:0], t.exp_f, t.exp_rd});
      @(negedge clk);
   endtask

   // Drives one LATENCY=4 request with valid held; reports acceptance cycle and
   // how many cycles ready was low before acceptance.
   task automatic drv4(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_f,
                       input logic push, output logic [31:0] acc, output int lows);
      bit got;
      v4 = 1'b1; wr4 = wr; a4 = addr; wd4 = wd; f34 = f3;
      lows = 0; got = 0; acc = '0;
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if (rdy4) begin
            got = 1;
            acc = cyc + 32'd1;
            if (push) exp_q4.push_back({acc[15:0] + 16'd3, exp_f, exp_rd});
         end else begin
            lows++;
         end
         @(negedge clk);
      end
      if (!got) chk("l4_accept_timeout", {31'd0, rdy4}, 32'd1);
   endtask

   task automatic drain(input int budget);
      for (int k = 0; k < budget && (exp_q1.size() != 0 || exp_q4.size() != 0); k++)
         @(negedge clk);
      chk("queues_drained", exp_q1.size() + exp_q4.size(), 32'd0);
   endtask

   initial begin
      logic [31:0] acc_a, acc_b, acc_c, acc_r;
      int          low_a, low_b, low_c, low_r;

      tbl.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 32'h20,  32'h8081F2F3, 3'b010, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h21,  32'h0,        3'b000, 32'hFFFFFFF2, 1'b0});
      tbl.push_back('{1'b0, 32'h21,  32'h0,        3'b100, 32'h000000F2, 1'b0});
      tbl.push_back('{1'b0, 32'h22,  32'h0,        3'b001, 32'hFFFF8081, 1'b0});
      tbl.push_back('{1'b0, 32'h22,  32'h0,        3'b101, 32'h00008081, 1'b0});
      tbl.push_back('{1'b0, 32'h20,  32'h0,        3'b000, 32'hFFFFFFF3, 1'b0});
      tbl.push_back('{1'b1, 32'h23,  32'h123456AA, 3'b000, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h20,  32'h0,        3'b010, 32'hAA81F2F3, 1'b0});
      tbl.push_back('{1'b0, 32'h23,  32'h0,        3'b100, 32'h000000AA, 1'b0});
      tbl.push_back('{1'b1, 32'h20,  32'hFFFF1234, 3'b001, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'h20,  32'h0,        3'b010, 32'hAA811234, 1'b0});
      tbl.push_back('{1'b0, 32'h20,  32'h0,        3'b001, 32'h00001234, 1'b0});
      tbl.push_back('{1'b0, 32'h22,  32'h0,        3'b010, 32'h0,        1'b1});
      tbl.push_back('{1'b0, 32'h21,  32'h0,        3'b001, 32'h0,        1'b1});
      tbl.push_back('{1'b1, 32'h100, 32'h11111111, 3'b010, 32'h0,        1'b1});
      tbl.push_back('{1'b0, 32'h20,  32'h0,        3'b011, 32'h0,        1'b1});
      tbl.push_back('{1'b1, 32'h20,  32'h00000055, 3'b100, 32'h0,        1'b1});
      tbl.push_back('{1'b1, 32'h22,  32'h0,        3'b010, 32'h0,        1'b1});
      tbl.push_back('{1'b1, 32'h10,  32'h0,        3'b110, 32'h0,        1'b1});
      tbl.push_back('{1'b1, 32'h21,  32'h00007777, 3'b001, 32'h0,        1'b1});
      tbl.push_back('{1'b0, 32'h20,  32'h0,        3'b010, 32'hAA811234, 1'b0});
      tbl.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
      tbl.push_back('{1'b1, 32'hFC,  32'h0BADF00D, 3'b010, 32'h0,        1'b0});
      tbl.push_back('{1'b0, 32'hFE,  32'h0,        3'b001, 32'h00000BAD, 1'b0});
      tbl.push_back('{1'b0, 32'hFC,  32'h0,        3'b010, 32'h0BADF00D, 1'b0});

      // Reset state
      @(negedge clk);
      mon_en = 1'b1;
      repeat (2) begin
         chk("rst_ready_l1", {31'd0, rdy1}, 32'd0);
         chk("rst_ready_l4", {31'd0, rdy4}, 32'd0);
         chk("rst_resp_l1", {31'd0, rv1}, 32'd0);
         @(negedge clk);
      end
      rst1 = 1'b0; rst4 = 1'b0;
      #1;
      chk("post_rst_ready_l1", {31'd0, rdy1}, 32'd1);
      chk("post_rst_ready_l4", {31'd0, rdy4}, 32'd1);
      @(negedge clk);

      // LATENCY=1: table applied back-to-back, one request per cycle
      for (int i = 0; i < tbl.size(); i++) drv1(tbl[i]);
      v1 = 1'b0;
      drain(10);

      // LATENCY=4: valid held high across three requests
      drv4(1'b1, 32'h40, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0, 1'b1, acc_a, low_a);
      drv4(1'b0, 32'h40, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 1'b1, acc_b, low_b);
      drv4(1'b0, 32'h42, 32'h0,        3'b101, 32'h0000CAFE, 1'b0, 1'b1, acc_c, low_c);
      v4 = 1'b0;
      chk("l4_spacing_ab", acc_b - acc_a, 32'd4);
      chk("l4_spacing_bc", acc_c - acc_b, 32'd4);
      chk("l4_ready_low_b", low_b, 32'd3);
      chk("l4_ready_low_c", low_c, 32'd3);
      drain(12);

      // Reset two cycles after accepting a load: its response must never appear
      drv4(1'b0, 32'h40, 32'h0, 3'b010, 32'h0, 1'b0, 1'b0, acc_r, low_r);
      v4 = 1'b0;
      @(negedge clk);
      rst4 = 1'b1;
      #1;
      chk("l4_mid_rst_ready", {31'd0, rdy4}, 32'd0);
      @(negedge clk);
      chk("l4_mid_rst_ready2", {31'd0, rdy4}, 32'd0);
      chk("l4_mid_rst_resp", {31'd0, rv4}, 32'd0);
      @(negedge clk);
      rst4 = 1'b0;
      #1;
      chk("l4_after_rst_ready", {31'd0, rdy4}, 32'd1);
      repeat (3) @(negedge clk);
      drv4(1'b0, 32'h40, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 1'b1, acc_r, low_r);
      drv4(1'b0, 32'h43, 32'h0, 3'b000, 32'hFFFFFFCA, 1'b0, 1'b1, acc_r, low_r);
      v4 = 1'b0;
      drain(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
